boot_copier: RTL and testbench
==============================

Name: boot_copier

Overview:
- Parametrised boot engine. After reset it copies WORDS 32-bit words from a synchronous boot ROM into BANKS word-interleaved RAM banks, then releases the core by asserting boot.
- Optional read-back verify pass, running 32-bit checksum, error reporting, and software/debug-triggered re-boot.
- Sits in the top level between the boot ROM, the RAM banks and core_top. The top muxes RAM ports to the core when boot=1.

Parameters:
WORDS, 512, number of 32-bit words copied (>=2)
ROM_AW, 9, ROM word address width; 2^ROM_AW >= WORDS
RAM_AW, 14, per-bank RAM word address width
BANKS, 2, interleaved banks, power of two (1,2,4)
BASE, 0, per-bank destination word offset
VERIFY, 1, 1 = read-back compare pass before release

Ports:
clk  in  1  clock
resetb  in  1  reset
reboot_req  in  1  single-cycle restart request (honoured only in DONE/FAIL)
rom_addr  out  ROM_AW  ROM word address
rom_data  in  32  ROM data, valid 1 cycle after rom_addr
ram_addr  out  RAM_AW  bank word address, shared by all banks
ram_di  out  32  write data, shared
ram_we  out  BANKS  per-bank write enable
ram_do  in  32*BANKS  bank read data, bank b at [32b+:32], 1-cycle latency
boot  out  1  1 = copy complete, core released
busy  out  1  1 = PRIME/COPY/VPRIME/VERIFY
error  out  1  verify mismatch, sticky until reboot/reset
fail_index  out  ROM_AW  word index of first mismatch
checksum  out  32  mod-2^32 sum of all words written

Behaviour:
- Reset is resetb, synchronous, active-low; clock clk.
- Reset values: state=PRIME, boot=0, busy=1, error=0, fail_index=0, checksum=0, ram_we=0, idx=0.
- Reset asserted mid-operation aborts immediately to the reset state and restarts the copy.
- Word mapping: word i -> bank i%BANKS, address BASE + i/BANKS, using low bits for bank select and a shift for the address.
- PRIME (1 cycle): rom_addr=0, ram_we=0 -> COPY.
- COPY: cycle k (k=0..WORDS-1):
  - write word k: ram_we one-hot at bank k%BANKS, ram_addr/ram_di = mapping/rom_data;
  - checksum += rom_data;
  - rom_addr = k+1 (don't-care on last cycle).
  - After k=WORDS-1 -> VPRIME if VERIFY else DONE.
- VPRIME (1 cycle): rom_addr=0, ram_addr=map(0), ram_we=0 -> VERIFY.
- VERIFY: cycle k:
  - compare rom_data against ram_do slice of bank k%BANKS (bank select registered from the previous cycle);
  - concurrently issue rom_addr/ram_addr for k+1.
  - Mismatch -> FAIL next cycle, fail_index=k latched, error=1.
  - All match after k=WORDS-1 -> DONE.
- DONE: boot=1, busy=0, ram_we=0; ram_addr/ram_di held 0.
- FAIL: boot=0 (core stays held), busy=0, error=1, ram_we=0.
- reboot_req:
  - in DONE/FAIL -> PRIME next cycle: boot drops that cycle; error, checksum, fail_index cleared.
  - in any busy state: ignored (no restart, no queuing).
- Latency from reset release, counting the first cycle with resetb=1 as cycle 0:
  - boot=1 at cycle WORDS+1 when VERIFY=0;
  - boot=1 at cycle 2*WORDS+2 when VERIFY=1.
- ram_we is never asserted outside COPY, and at most one bit is set.
- Index counter width is ROM_AW+1, so there is no wrap at WORDS=2^ROM_AW.

Test Plan:
- WORDS=8, BANKS=2, BASE=0, VERIFY=0, ROM[i]=0x1000+i -> bank0 addr0..3 = 0x1000,1002,1004,1006; bank1 = 0x1001,1003,1005,1007; boot rises at cycle 9; checksum=0x801C.
- Same ROM, VERIFY=1, RAM model correct -> boot at cycle 18, error=0.
- VERIFY=1, RAM model corrupts bank1 addr2 (word 5) -> FAIL; error=1, fail_index=5, boot stays 0 for 100 cycles.
- From FAIL, clean RAM, pulse reboot_req -> next cycle busy=1, error=0; boot=1 exactly 19 cycles after the pulse.
- BANKS=4, BASE=16, WORDS=8 -> word 6 written to bank2 addr 17; no write outside addr 16..17; reboot_req pulsed mid-COPY is ignored (boot at cycle 9, single pass).
- Assert resetb=0 at COPY k=4, release -> copy restarts from word 0; checksum equals a fresh run (0x801C).

Source files
------------

// File: rtl/boot_copier.sv
// boot_copier: copies WORDS boot-ROM words into BANKS interleaved RAM banks,
// optionally read-back verifies them, then releases the core via boot.
module boot_copier #(
    parameter int WORDS  = 512,
    parameter int ROM_AW = 9,
    parameter int RAM_AW = 14,
    parameter int BANKS  = 2,
    parameter int BASE   = 0,
    parameter int VERIFY = 1
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  reboot_req,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [31:0]           rom_data,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [31:0]           ram_di,
    output logic [BANKS-1:0]      ram_we,
    input  logic [32*BANKS-1:0]   ram_do,
    output logic                  boot,
    output logic                  busy,
    output logic                  error,
    output logic [ROM_AW-1:0]     fail_index,
    output logic [31:0]           checksum
);
    localparam int IW = ROM_AW + 1;
    localparam int BW = $clog2(BANKS);

    typedef enum logic [2:0] {S_PRIME, S_COPY, S_VPRIME, S_VERIFY, S_DONE, S_FAIL} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_nx, sel_q;
    logic            last, mismatch, restart;

    assign idx_nx   = idx + IW'(1);
    assign last     = idx == IW'(WORDS - 1);
    // sel_q holds the bank of the address issued last cycle, matching ram_do latency
    assign mismatch = state == S_VERIFY && rom_data != ram_do[32*sel_q +: 32];
    assign restart  = (state == S_DONE || state == S_FAIL) && reboot_req;

    always_ff @(posedge clk) begin
        if (!resetb)
            state <= S_PRIME;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_PRIME:  state_n = S_COPY;
            S_COPY:   state_n = last ? (VERIFY != 0 ? S_VPRIME : S_DONE) : S_COPY;
            S_VPRIME: state_n = S_VERIFY;
            S_VERIFY: state_n = mismatch ? S_FAIL : last ? S_DONE : S_VERIFY;
            S_DONE:   state_n = reboot_req ? S_PRIME : S_DONE;
            S_FAIL:   state_n = reboot_req ? S_PRIME : S_FAIL;
            default:  state_n = S_PRIME;
        endcase
    end

    always_comb begin
        rom_addr = (state == S_COPY || state == S_VERIFY) ? ROM_AW'(idx_nx) : '0;
        ram_addr = state == S_COPY   ? RAM_AW'(BASE) + RAM_AW'(idx >> BW) :
                   state == S_VPRIME ? RAM_AW'(BASE) :
                   state == S_VERIFY ? RAM_AW'(BASE) + RAM_AW'(idx_nx >> BW) : '0;
        ram_di   = state == S_COPY ? rom_data : '0;
        ram_we   = state == S_COPY ? BANKS'(1) << (idx & IW'(BANKS - 1)) : '0;
        boot     = state == S_DONE;
        busy     = state == S_PRIME || state == S_COPY || state == S_VPRIME || state == S_VERIFY;
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            idx        <= '0;
            sel_q      <= '0;
            checksum   <= '0;
            error      <= 1'b0;
            fail_index <= '0;
        end else begin
            idx   <= ((state == S_COPY || state == S_VERIFY) && !last) ? idx_nx : '0;
            sel_q <= state == S_VERIFY ? (idx_nx & IW'(BANKS - 1)) : '0;
            if (restart) begin
                checksum   <= '0;
                error      <= 1'b0;
                fail_index <= '0;
            end else begin
                if (state == S_COPY)
                    checksum <= checksum + rom_data;
                if (mismatch) begin
                    error      <= 1'b1;
                    fail_index <= idx[ROM_AW-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier: three boot_copier configurations against ROM/RAM models and a mapping-based reference.
module tb_boot_copier;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rstb = 3'b000, rreq = 3'b000;
    logic [31:0] rom [W];
    logic [2:0]  ra [3];
    logic [31:0] rd [3];
    logic [5:0]  aa [3];
    logic [31:0] di [3];
    logic [2:0]  fi [3];
    logic [31:0] cs [3];
    logic [2:0]  boot, busy, err;
    logic [1:0]  we0, we1;
    logic [3:0]  we2;
    logic [63:0] do0, do1;
    logic [127:0] do2;
    logic [31:0] m0 [2][64];
    logic [31:0] m1 [2][64];
    logic [31:0] m2 [4][64];
    int bad_we = 0, bad_addr = 0, wcnt2 = 0;
    int corrupt = 0, cb = 0, ca = 0;
    int tests = 0, fails = 0;

    boot_copier #(.WORDS(W), .ROM_AW(3), .RAM_AW(6), .BANKS(2), .BASE(0), .VERIFY(0)) u_d0 (
        .clk(clk), .resetb(rstb[0]), .reboot_req(rreq[0]), .rom_addr(ra[0]), .rom_data(rd[0]),
        .ram_addr(aa[0]), .ram_di(di[0]), .ram_we(we0), .ram_do(do0), .boot(boot[0]), .busy(busy[0]),
        .error(err[0]), .fail_index(fi[0]), .checksum(cs[0]));
    boot_copier #(.WORDS(W), .ROM_AW(3), .RAM_AW(6), .BANKS(2), .BASE(0), .VERIFY(1)) u_d1 (
        .clk(clk), .resetb(rstb[1]), .reboot_req(rreq[1]), .rom_addr(ra[1]), .rom_data(rd[1]),
        .ram_addr(aa[1]), .ram_di(di[1]), .ram_we(we1), .ram_do(do1), .boot(boot[1]), .busy(busy[1]),
        .error(err[1]), .fail_index(fi[1]), .checksum(cs[1]));
    boot_copier #(.WORDS(W), .ROM_AW(3), .RAM_AW(6), .BANKS(4), .BASE(16), .VERIFY(0)) u_d2 (
        .clk(clk), .resetb(rstb[2]), .reboot_req(rreq[2]), .rom_addr(ra[2]), .rom_data(rd[2]),
        .ram_addr(aa[2]), .ram_di(di[2]), .ram_we(we2), .ram_do(do2), .boot(boot[2]), .busy(busy[2]),
        .error(err[2]), .fail_index(fi[2]), .checksum(cs[2]));

    // synchronous ROM and RAM models; d1 can be told to store one word inverted
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rd[i] <= rom[ra[i]];
        for (int b = 0; b < 2; b++) begin
            if (we0[b]) m0[b][aa[0]] <= di[0];
            do0[32*b +: 32] <= m0[b][aa[0]];
            if (we1[b]) m1[b][aa[1]] <= (corrupt != 0 && b == cb && int'(aa[1]) == ca) ? ~di[1] : di[1];
            do1[32*b +: 32] <= m1[b][aa[1]];
        end
        for (int b = 0; b < 4; b++) begin
            if (we2[b]) m2[b][aa[2]] <= di[2];
            do2[32*b +: 32] <= m2[b][aa[2]];
        end
        if ($countones(we0) > 1 || $countones(we1) > 1 || $countones(we2) > 1) bad_we <= bad_we + 1;
        if ((we0 != 0 && !busy[0]) || (we1 != 0 && !busy[1]) || (we2 != 0 && !busy[2])) bad_we <= bad_we + 1;
        if (we2 != 0 && (aa[2] < 16 || aa[2] > 17)) bad_addr <= bad_addr + 1;
        if (we2 != 0) wcnt2 <= wcnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] we_of(input int d);
        return d == 0 ? {2'b00, we0} : d == 1 ? {2'b00, we1} : we2;
    endfunction

    function automatic logic [31:0] exp_sum();
        logic [31:0] s = 0;
        for (int i = 0; i < W; i++) s += rom[i];
        return s;
    endfunction

    // called at a negedge; leaves at the negedge that starts cycle 0 (resetb=1)
    task automatic do_reset(input int d);
        rstb[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("rst%0d_boot", d), boot[d], 0);
        check($sformatf("rst%0d_busy", d), busy[d], 1);
        check($sformatf("rst%0d_err", d), err[d], 0);
        check($sformatf("rst%0d_sum", d), cs[d], 0);
        check($sformatf("rst%0d_fi", d), fi[d], 0);
        check($sformatf("rst%0d_we", d), we_of(d), 0);
        rstb[d] = 1'b1;
    endtask

    task automatic boot_wait(input int d, output int n);
        n = 0;
        while (!boot[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic idle_wait(input int d, output int n);
        n = 0;
        while (busy[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // reference placement: word i lives in bank i%B at BASE + i/B
    task automatic check_ram(input int d);
        int nb, base, b, a;
        logic [31:0] got;
        nb = d == 2 ? 4 : 2;
        base = d == 2 ? 16 : 0;
        for (int i = 0; i < W; i++) begin
            b = i % nb;
            a = base + i / nb;
            got = d == 0 ? m0[b][a] : d == 1 ? m1[b][a] : m2[b][a];
            check($sformatf("ram%0d_w%0d", d, i), got, rom[i]);
        end
    endtask

    initial begin
        int n, seen, j;
        for (int i = 0; i < W; i++) rom[i] = 32'h1000 + i;
        @(negedge clk);

        do_reset(0);
        boot_wait(0, n);
        check("d0_boot_cycle", n, W + 1);
        check_ram(0);
        check("d0_sum", cs[0], 32'h801C);

        do_reset(1);
        boot_wait(1, n);
        check("d1_boot_cycle", n, 2 * W + 2);
        check("d1_err", err[1], 0);
        check("d1_sum", cs[1], 32'h801C);

        corrupt = 1; cb = 1; ca = 2;
        do_reset(1);
        idle_wait(1, n);
        check("d1_fail_cycle", n, W + 3 + 5);
        check("d1_fail_err", err[1], 1);
        check("d1_fail_idx", fi[1], 5);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (boot[1]) seen++;
        end
        check("d1_fail_hold", seen, 0);
        check("d1_fail_sticky", err[1], 1);

        corrupt = 0;
        rreq[1] = 1'b1;
        @(negedge clk);
        rreq[1] = 1'b0;
        check("d1_rb_busy", busy[1], 1);
        check("d1_rb_err", err[1], 0);
        check("d1_rb_sum", cs[1], 0);
        check("d1_rb_fi", fi[1], 0);
        boot_wait(1, n);
        check("d1_rb_latency", n + 1, 2 * W + 3);
        check("d1_rb_err2", err[1], 0);
        check_ram(1);

        do_reset(2);
        repeat (4) @(negedge clk);
        rreq[2] = 1'b1;
        @(negedge clk);
        rreq[2] = 1'b0;
        boot_wait(2, n);
        check("d2_boot_cycle", n + 5, W + 1);
        repeat (20) @(negedge clk);
        check("d2_still_boot", boot[2], 1);
        check("d2_writes", wcnt2, W);
        check("d2_w6", m2[2][17], rom[6]);
        check_ram(2);
        check("d2_addr_range", bad_addr, 0);

        do_reset(0);
        repeat (5) @(negedge clk);
        check("d0_we_k4", we0, 2'b01);
        do_reset(0);
        boot_wait(0, n);
        check("d0_restart_cycle", n, W + 1);
        check("d0_restart_sum", cs[0], 32'h801C);
        check_ram(0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < W; i++) rom[i] = $urandom;
            do_reset(0);
            boot_wait(0, n);
            check("rnd_d0_cycle", n, W + 1);
            check("rnd_d0_sum", cs[0], exp_sum());
            check_ram(0);
            j = $urandom_range(W - 1, 0);
            corrupt = $urandom_range(1, 0);
            cb = j % 2; ca = j / 2;
            do_reset(1);
            if (corrupt != 0) begin
                idle_wait(1, n);
                check("rnd_d1_fail_cycle", n, W + 3 + j);
                check("rnd_d1_err", err[1], 1);
                check("rnd_d1_fi", fi[1], j);
                check("rnd_d1_boot", boot[1], 0);
            end else begin
                boot_wait(1, n);
                check("rnd_d1_cycle", n, 2 * W + 2);
                check("rnd_d1_err", err[1], 0);
                check_ram(1);
            end
            check("rnd_d1_sum", cs[1], exp_sum());
            corrupt = 0;
        end

        check("we_onehot_in_copy", bad_we, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
